uart_rx_ctrl: RTL and testbench

Sequencing and configuration controller for the `clk_16bd`-domain UART receive processor. The block holds the live line configuration that drives the processor: `frame_length`, `parity`, `parity_type` and `stop_bits`. It applies host configuration changes only while the serial line is idle, and re-arms the processor through `proc_rst` after every received frame, because the processor's frame register and valid flag are sticky. Captured frames are buffered in a small FIFO with a valid/ready output, and a watchdog recovers the processor from stuck or dropped frames.

---
 rtl/uart_rx_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Sequencing/configuration controller for the clk_16bd-domain UART receive processor.
// Define UART_RX_CTRL_TIMEOUT_EN to build the stuck-frame watchdog; without it err_timeout is tied low.
module uart_rx_ctrl #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned IDLE_BITS    = 2,
   parameter int unsigned TIMEOUT_BITS = 12
) (
   input  logic       clk_16bd,
   input  logic       rst,
   input  logic       rx,
   input  logic       cfg_wr,
   input  logic [6:0] cfg_data,
   output logic       cfg_busy,
   output logic [3:0] frame_length,
   output logic       parity,
   output logic       parity_type,
   output logic       stop_bits,
   input  logic [8:0] proc_frame,
   input  logic       proc_frame_valid,
   output logic       proc_rst,
   output logic [8:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       overflow,
   input  logic       ovf_clr,
   output logic       err_timeout
);

   localparam int unsigned IDLE_MAX  = IDLE_BITS * 16;
   localparam int unsigned IDLE_W    = $clog2(IDLE_MAX + 1);
   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [6:0]  CFG_RESET = 7'h08;

   typedef enum logic [2:0] {
      QUAL    = 3'd0,
      APPLY   = 3'd1,
      ARM     = 3'd2,
      CAPTURE = 3'd3,
      RECOVER = 3'd4
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [IDLE_W-1:0] idle_cnt;
   logic              line_idle;
   logic              frame_active;
   logic              wd_fire;
   logic [6:0]        cfg_shadow;
   logic [6:0]        cfg_live;
   logic [8:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_full;
   logic              push_req;
   logic              push;
   logic              pop;

   // NOTE: every clocked process uses <= so all flops sample the same pre-edge values.
   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst)
         idle_cnt <= '0;
      else if (!rx)
         idle_cnt <= '0;
      else if (!line_idle)
         idle_cnt <= idle_cnt + IDLE_W'(1);
   end

   assign line_idle = (idle_cnt == IDLE_W'(IDLE_MAX));

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst)
         state <= QUAL;
      else
         state <= next_state;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
      next_state = state;
      case (state)
         QUAL:    if (line_idle) next_state = cfg_busy ? APPLY : ARM;
         APPLY:   next_state = ARM;
         ARM: begin
            if (proc_frame_valid)
               next_state = CAPTURE;
            else if (wd_fire)
               next_state = QUAL;
            else if (cfg_busy && !frame_active)
               next_state = QUAL;
         end
         CAPTURE: next_state = cfg_busy ? QUAL : RECOVER;
         RECOVER: next_state = ARM;
         default: next_state = QUAL;
      endcase
   end

   // Registered so the processor sees a glitch-free reset; low only in ARM and CAPTURE.
   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst)
         proc_rst <= 1'b1;
      else
         proc_rst <= (next_state == QUAL) || (next_state == APPLY) || (next_state == RECOVER);
   end

   // A low rx sample always means the line is busy, so set outranks the idle clear.
   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst)
         frame_active <= 1'b0;
      else if (next_state == CAPTURE || next_state == QUAL)
         frame_active <= 1'b0;
      else if (state == ARM && !rx)
         frame_active <= 1'b1;
      else if (line_idle)
         frame_active <= 1'b0;
   end

   // A write landing in APPLY keeps the new value pending while the old shadow goes live.
   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst) begin
         cfg_shadow <= CFG_RESET;
         cfg_live   <= CFG_RESET;
         cfg_busy   <= 1'b0;
      end else begin
         if (state == APPLY)
            cfg_live <= cfg_shadow;
         if (cfg_wr) begin
            cfg_shadow <= cfg_data;
            cfg_busy   <= 1'b1;
         end else if (state == APPLY) begin
            cfg_busy <= 1'b0;
         end
      end
   end

   assign frame_length = cfg_live[3:0];
   assign parity       = cfg_live[4];
   assign parity_type  = cfg_live[5];
   assign stop_bits    = cfg_live[6];

   assign out_valid = (fifo_cnt != '0);
   assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign pop       = out_valid && out_ready;
   assign push_req  = (state == CAPTURE);
   assign push      = push_req && (!fifo_full || pop);
   assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

   // NOTE: storage is not reset; out_data is masked while empty so stale entries never escape.
   always_ff @(posedge clk_16bd) begin
      if (push)
         fifo_mem[wr_ptr] <= proc_frame;
   end

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            fifo_cnt <= fifo_cnt + CNT_W'(1);
         else if (pop && !push)
            fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (push_req && fifo_full && !pop)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

   logic [TIMEOUT_BITS-1:0] wd_cnt;

   // Fires on the clock that takes the counter to all-ones.
   assign wd_fire = (state == ARM) && frame_active && (wd_cnt == WD_LAST);

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst) begin
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= wd_fire;
         if (!frame_active)
            wd_cnt <= '0;
         else if (state == ARM)
            wd_cnt <= wd_cnt + TIMEOUT_BITS'(1);
      end
   end
`else
   assign wd_fire     = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: reset/arm, capture, deferred config, FIFO overflow, watchdog, async reset.
module tb_uart_rx_ctrl;

   localparam int unsigned FIFO_DEPTH   = 4;
   localparam int unsigned IDLE_BITS    = 2;
   localparam int unsigned TIMEOUT_BITS = 6;

   logic       clk_16bd;
   logic       rst;
   logic       rx;
   logic       cfg_wr;
   logic [6:0] cfg_data;
   logic       cfg_busy;
   logic [3:0] frame_length;
   logic       parity;
   logic       parity_type;
   logic       stop_bits;
   logic [8:0] proc_frame;
   logic       proc_frame_valid;
   logic       proc_rst;
   logic [8:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       overflow;
   logic       ovf_clr;
   logic       err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx_ctrl #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .IDLE_BITS   (IDLE_BITS),
      .TIMEOUT_BITS(TIMEOUT_BITS)
   ) dut (
      .clk_16bd        (clk_16bd),
      .rst             (rst),
      .rx              (rx),
      .cfg_wr          (cfg_wr),
      .cfg_data        (cfg_data),
      .cfg_busy        (cfg_busy),
      .frame_length    (frame_length),
      .parity          (parity),
      .parity_type     (parity_type),
      .stop_bits       (stop_bits),
      .proc_frame      (proc_frame),
      .proc_frame_valid(proc_frame_valid),
      .proc_rst        (proc_rst),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .overflow        (overflow),
      .ovf_clr         (ovf_clr),
      .err_timeout     (err_timeout)
   );

   initial clk_16bd = 1'b0;
   always #5 clk_16bd = ~clk_16bd;

   initial begin
      #200_000;
      $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "bench timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_16bd);
   endtask

   // Waits (bounded) until the controller arms the processor.
   task automatic wait_arm(input string tag);
      for (int k = 0; k < 200; k++) begin
         if (proc_rst === 1'b0) break;
         @(negedge clk_16bd);
      end
      n_checks++;
      if (proc_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_arm: proc_rst=%b after 200 cycles, expected 0", tag, proc_rst);
      end
   endtask

   // Presents one frame in ARM; returns at the negedge after RECOVER (back in ARM).
   task automatic send_frame(input logic [8:0] d);
      proc_frame       = d;
      proc_frame_valid = 1'b1;
      @(negedge clk_16bd);
      proc_frame_valid = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      int fall_at;
      fall_at          = -1;
      rst              = 1'b1;
      rx               = 1'b1;
      cfg_wr           = 1'b0;
      cfg_data         = 7'h00;
      proc_frame       = 9'h000;
      proc_frame_valid = 1'b0;
      out_ready        = 1'b0;
      ovf_clr          = 1'b0;
      tick(3);
      n_checks++;
      if (proc_rst !== 1'b1) begin n_fail++; $display("FAIL reset_proc_rst: got %b, expected 1", proc_rst); end
      n_checks++;
      if ({frame_length, parity, parity_type, stop_bits} !== 7'b1000_000) begin
         n_fail++;
         $display("FAIL reset_cfg: got fl=%0d p=%b pt=%b sb=%b, expected fl=8 p=0 pt=0 sb=0",
                  frame_length, parity, parity_type, stop_bits);
      end
      n_checks++;
      if ({cfg_busy, out_valid, overflow, err_timeout} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got busy=%b valid=%b ovf=%b tmo=%b, expected all 0",
                  cfg_busy, out_valid, overflow, err_timeout);
      end
      n_checks++;
      if (out_data !== 9'h000) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 000", out_data); end
      rst = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk_16bd);
         if (proc_rst === 1'b0) begin
            fall_at = k;
            break;
         end
      end
      n_checks++;
      if (fall_at != 33) begin n_fail++; $display("FAIL first_arm: proc_rst fell after %0d clocks, expected 33", fall_at); end
   endtask

   task automatic test_single_frame();
      out_ready        = 1'b0;
      proc_frame       = 9'h0A5;
      proc_frame_valid = 1'b1;
      @(negedge clk_16bd);
      proc_frame_valid = 1'b0;
      n_checks++;
      if ({out_valid, proc_rst} !== 2'b00) begin
         n_fail++;
         $display("FAIL capture_cycle: got valid=%b proc_rst=%b, expected 0 0", out_valid, proc_rst);
      end
      @(negedge clk_16bd);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h0A5) begin
         n_fail++;
         $display("FAIL single_frame_data: got valid=%b data=%h, expected 1 0a5", out_valid, out_data);
      end
      n_checks++;
      if (proc_rst !== 1'b1) begin n_fail++; $display("FAIL recover_proc_rst: got %b, expected 1", proc_rst); end
      @(negedge clk_16bd);
      n_checks++;
      if (proc_rst !== 1'b0) begin n_fail++; $display("FAIL recover_one_cycle: got proc_rst=%b, expected 0", proc_rst); end
      out_ready = 1'b1;
      @(negedge clk_16bd);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 9'h000) begin
         n_fail++;
         $display("FAIL single_frame_pop: got valid=%b data=%h, expected 0 000", out_valid, out_data);
      end
   endtask

   task automatic test_deferred_cfg();
      rx = 1'b0;
      @(negedge clk_16bd);
      cfg_wr   = 1'b1;
      cfg_data = 7'h57;
      @(negedge clk_16bd);
      cfg_wr = 1'b0;
      n_checks++;
      if (cfg_busy !== 1'b1 || frame_length !== 4'd8 || proc_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_pending: got busy=%b fl=%0d proc_rst=%b, expected 1 8 0", cfg_busy, frame_length, proc_rst);
      end
      tick(8);
      n_checks++;
      if ({frame_length, parity, parity_type, stop_bits} !== 7'b1000_000 || proc_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_held_in_frame: got fl=%0d p=%b sb=%b proc_rst=%b, expected 8 0 0 0",
                  frame_length, parity, stop_bits, proc_rst);
      end
      rx               = 1'b1;
      proc_frame       = 9'h1C3;
      proc_frame_valid = 1'b1;
      @(negedge clk_16bd);
      proc_frame_valid = 1'b0;
      @(negedge clk_16bd);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h1C3 || proc_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_frame_capture: got valid=%b data=%h proc_rst=%b, expected 1 1c3 1", out_valid, out_data, proc_rst);
      end
      tick(31);
      n_checks++;
      if (frame_length !== 4'd8 || cfg_busy !== 1'b1 || proc_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_in_apply: got fl=%0d busy=%b proc_rst=%b, expected 8 1 1", frame_length, cfg_busy, proc_rst);
      end
      @(negedge clk_16bd);
      n_checks++;
      if ({frame_length, parity, parity_type, stop_bits} !== 7'b0111_101) begin
         n_fail++;
         $display("FAIL cfg_applied: got fl=%0d p=%b pt=%b sb=%b, expected fl=7 p=1 pt=0 sb=1",
                  frame_length, parity, parity_type, stop_bits);
      end
      n_checks++;
      if (cfg_busy !== 1'b0 || proc_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_after_apply: got busy=%b proc_rst=%b, expected 0 0", cfg_busy, proc_rst);
      end
      out_ready = 1'b1;
      @(negedge clk_16bd);
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [8:0] exp_d [4];
      exp_d = '{9'h102, 9'h103, 9'h104, 9'h0C4};
      for (int i = 0; i < 4; i++) send_frame(9'h101 + 9'(i));
      n_checks++;
      if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== 9'h101) begin
         n_fail++;
         $display("FAIL fifo_fill: got ovf=%b valid=%b data=%h, expected 0 1 101", overflow, out_valid, out_data);
      end
      send_frame(9'h1FF);
      n_checks++;
      if (overflow !== 1'b1 || out_data !== 9'h101) begin
         n_fail++;
         $display("FAIL fifo_overflow: got ovf=%b data=%h, expected 1 101", overflow, out_data);
      end
      ovf_clr = 1'b1;
      @(negedge clk_16bd);
      ovf_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
      // Push and pop on the same edge while full.
      proc_frame       = 9'h0C4;
      proc_frame_valid = 1'b1;
      @(negedge clk_16bd);
      proc_frame_valid = 1'b0;
      out_ready        = 1'b1;
      @(negedge clk_16bd);
      out_ready = 1'b0;
      @(negedge clk_16bd);
      n_checks++;
      if (overflow !== 1'b0 || out_data !== 9'h102) begin
         n_fail++;
         $display("FAIL push_pop_full: got ovf=%b head=%h, expected 0 102", overflow, out_data);
      end
      // Drop coinciding with ovf_clr keeps the flag set.
      proc_frame       = 9'h1EE;
      proc_frame_valid = 1'b1;
      @(negedge clk_16bd);
      proc_frame_valid = 1'b0;
      ovf_clr          = 1'b1;
      @(negedge clk_16bd);
      ovf_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_collision: got %b, expected 1", overflow); end
      @(negedge clk_16bd);
      ovf_clr = 1'b1;
      @(negedge clk_16bd);
      ovf_clr   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
            n_fail++;
            $display("FAIL drain_%0d: got valid=%b data=%h, expected 1 %h", i, out_valid, out_data, exp_d[i]);
         end
         @(negedge clk_16bd);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got valid=%b, expected 0", out_valid); end
      @(negedge clk_16bd);
      out_ready = 1'b0;
      send_frame(9'h055);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h055) begin
         n_fail++;
         $display("FAIL pop_empty_ignored: got valid=%b data=%h, expected 1 055", out_valid, out_data);
      end
      out_ready = 1'b1;
      @(negedge clk_16bd);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL final_pop: got valid=%b, expected 0", out_valid); end
   endtask

   task automatic test_watchdog();
`ifdef UART_RX_CTRL_TIMEOUT_EN
      int fire_at;
      logic rst_at_fire;
      fire_at     = -1;
      rst_at_fire = 1'b0;
      rx          = 1'b0;
      // frame_active rises on the first edge; the counter then needs 63 clocks.
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk_16bd);
         if (err_timeout === 1'b1) begin
            fire_at     = k;
            rst_at_fire = proc_rst;
            break;
         end
      end
      n_checks++;
      if (fire_at != 64) begin n_fail++; $display("FAIL wd_latency: pulse after %0d clocks, expected 64", fire_at); end
      n_checks++;
      if (rst_at_fire !== 1'b1) begin n_fail++; $display("FAIL wd_proc_rst: got %b, expected 1", rst_at_fire); end
      @(negedge clk_16bd);
      n_checks++;
      if (err_timeout !== 1'b0 || proc_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_pulse_width: got tmo=%b proc_rst=%b, expected 0 1", err_timeout, proc_rst);
      end
      rx = 1'b1;
      wait_arm("watchdog");
`else
      int bad;
      bad = 0;
      rx  = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk_16bd);
         if (err_timeout !== 1'b0 || proc_rst !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL wd_disabled: %0d cycles with pulse or proc_rst, expected 0", bad); end
      rx = 1'b1;
      tick(40);
      n_checks++;
      if (err_timeout !== 1'b0 || proc_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_disabled_idle: got tmo=%b proc_rst=%b, expected 0 0", err_timeout, proc_rst);
      end
`endif
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      send_frame(9'h111);
      send_frame(9'h122);
      send_frame(9'h133);
      cfg_wr   = 1'b1;
      cfg_data = 7'h3F;
      rx       = 1'b0;
      @(negedge clk_16bd);
      cfg_wr = 1'b0;
      tick(2);
      n_checks++;
      if (cfg_busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 9'h111 || proc_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_reset_state: got busy=%b valid=%b data=%h proc_rst=%b, expected 1 1 111 0",
                  cfg_busy, out_valid, out_data, proc_rst);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 9'h000 || cfg_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_flush: got valid=%b data=%h busy=%b, expected 0 000 0", out_valid, out_data, cfg_busy);
      end
      n_checks++;
      if ({frame_length, parity, parity_type, stop_bits} !== 7'b1000_000 || proc_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset_cfg: got fl=%0d p=%b pt=%b sb=%b proc_rst=%b, expected 8 0 0 0 1",
                  frame_length, parity, parity_type, stop_bits, proc_rst);
      end
      @(negedge clk_16bd);
      rst = 1'b0;
      rx  = 1'b1;
      wait_arm("post_reset");
      n_checks++;
      if (frame_length !== 4'd8 || cfg_busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_cfg: got fl=%0d busy=%b valid=%b, expected 8 0 0", frame_length, cfg_busy, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_deferred_cfg();
      test_overflow();
      test_watchdog();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
